// File: rtl/updn_counter_gen.sv
// Parameterised up/down counter with parallel load, wrap or saturate at the
// boundaries, a one-cycle wrap pulse and sticky overflow/underflow flags.
module updn_counter_gen #(
  parameter int unsigned          WIDTH     = 8,
  parameter longint unsigned      MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter bit                   SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             ovf_evt;
  logic             udf_evt;

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    if (load) begin
      // Out-of-range load values clamp so count stays inside 0..MAX_COUNT.
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_down) begin
        if (at_max) begin
          ovf_evt = 1'b1;
          if (!SATURATE) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count + ONE;
        end
      end else begin
        if (at_min) begin
          udf_evt = 1'b1;
          if (!SATURATE) begin
            count_next = MAX_VAL;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
      // A boundary event on the same edge as a clear leaves the flag set.
      ovf   <= (ovf & ~clr_flags) | ovf_evt;
      udf   <= (udf & ~clr_flags) | udf_evt;
    end
  end

endmodule

// File: doc/updn_counter_gen.md
UPDN_COUNTER_GEN -- requirements
Module: updn_counter_gen

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits (legal range 2..32).
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, SHALL set the terminal value; legal range 1..2**WIDTH-1, so the count range is 0..MAX_COUNT.
REQ-003 Parameter SATURATE, default 0, SHALL select the boundary mode: 0 wraps, 1 holds at the boundary.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port en, input, 1 bit, SHALL be the count enable.
REQ-007 Port up_down, input, 1 bit, SHALL select direction: 1'b1 up, 1'b0 down.
REQ-008 Port load, input, 1 bit, SHALL be the synchronous parallel-load strobe.
REQ-009 Port load_val, input, WIDTH bits, SHALL be the value to load.
REQ-010 Port clr_flags, input, 1 bit, SHALL clear the sticky flags.
REQ-011 Port count, output, WIDTH bits, SHALL be the registered counter value.
REQ-012 Port at_max, output, 1 bit, SHALL be combinational and high when count==MAX_COUNT.
REQ-013 Port at_min, output, 1 bit, SHALL be combinational and high when count==0.
REQ-014 Port wrap, output, 1 bit, SHALL be a registered single-cycle pulse marking a wrap event.
REQ-015 Port ovf, output, 1 bit, SHALL be a sticky flag marking an up-step attempted at MAX_COUNT.
REQ-016 Port udf, output, 1 bit, SHALL be a sticky flag marking a down-step attempted at 0.

Function
REQ-017 Each clk edge SHALL resolve in strict priority: rst > load > en > hold.
REQ-018 load=1 SHALL set count to load_val, or to MAX_COUNT if load_val>MAX_COUNT; the load SHALL NOT change wrap, ovf or udf (wrap goes 0).
REQ-019 en=1, load=0, up_down=1, count<MAX_COUNT SHALL give count+1.
REQ-020 en=1, load=0, up_down=0, count>0 SHALL give count-1.
REQ-021 An up-step at MAX_COUNT SHALL behave as follows:
- SATURATE=0: count goes to 0 and wrap=1 on the next cycle.
- SATURATE=1: count holds and wrap stays 0.
- Both modes: ovf is set.
REQ-022 A down-step at 0 SHALL behave as follows:
- SATURATE=0: count goes to MAX_COUNT and wrap=1 on the next cycle.
- SATURATE=1: count holds and wrap stays 0.
- Both modes: udf is set.
REQ-023 wrap SHALL be 1 for exactly the cycle in which the wrapped count value is presented, and 0 in every other cycle, including hold, load and reset cycles.
REQ-024 en=0 with load=0 SHALL hold count; wrap=0; sticky flags unchanged.
REQ-025 clr_flags=1 SHALL clear ovf and udf on the next edge; if a new boundary event occurs on the same edge, set SHALL win over clear.
REQ-026 Arithmetic SHALL be WIDTH bits, unsigned; count SHALL never leave 0..MAX_COUNT, including when MAX_COUNT<2**WIDTH-1.
REQ-027 up_down SHALL be sampled only on edges with en=1 and load=0; a direction change takes effect on the very next step, with no dead cycle.
REQ-028 Latency from enable or load to the count update SHALL be one clock; there is no pipelining.

Reset
REQ-029 rst=1 at a clk edge SHALL force count=0, wrap=0, ovf=0, udf=0, regardless of load, en or clr_flags.
REQ-030 Following REQ-013 and REQ-029, at_min SHALL be 1 and at_max SHALL be 0 (MAX_COUNT>=1) after reset.
REQ-031 Reset asserted mid-count or mid-wrap SHALL discard the pending wrap pulse, with no residual effect on the cycle after rst deasserts.

Verification (WIDTH=4, MAX_COUNT=9)
REQ-032 Wrap up, SATURATE=0: reset, then en=1, up_down=1 for 10 cycles -> count 1..9 then 0; wrap=1 only with count=0; ovf=1.
REQ-033 Wrap down, SATURATE=0: reset, then en=1, up_down=0 for 1 cycle -> count=9, wrap=1, udf=1, at_max=1.
REQ-034 Saturate, SATURATE=1: load 8, then up 3 cycles -> count 9,9,9; wrap never 1; ovf=1 from the 2nd step.
REQ-035 Load clamp and priority: load=1, load_val=13, en=1, up_down=1 -> count=9 next cycle, no flag change; then load=0 -> normal stepping resumes.
REQ-036 Flag set/clear race: count=9, up-step with clr_flags=1 -> ovf=1; next cycle clr_flags=1, en=0 -> ovf=0.
REQ-037 Reset override: count=5 with en=1, load=1, clr_flags=1, rst=1 -> count=0, all flags 0, at_min=1; at rst release, stepping resumes from 0.
